// File: rtl/shift_ring_counter.sv
// rtl/shift_ring_counter.sv - ring / Johnson shift counter with load, direction and terminal count
// Define SHIFT_RING_COUNTER_SELFCORRECT_EN to decode illegal states and recover to the start state.
module shift_ring_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             illegal
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] edges;
  logic             legal;

  always_comb begin
    start_val = mode ? '0 : WIDTH'(1);

    // Bit i marks a boundary between Q[i] and Q[i+1]; the MSB has no upper neighbour.
    edges = (q_q ^ (q_q >> 1)) & {1'b0, {(WIDTH-1){1'b1}}};
    legal = mode ? $onehot0(edges) : $onehot(q_q);

    case ({mode, dir})
      2'b00:   shift_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      2'b01:   shift_val = {q_q[0], q_q[WIDTH-1:1]};
      2'b10:   shift_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      default: shift_val = {~q_q[0], q_q[WIDTH-1:1]};
    endcase

    tc = clr_n & en & ~load & legal & (shift_val == start_val);

`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
    illegal = ~legal;
`else
    illegal = 1'b0;
`endif

    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = shift_val;
      // An empty ring would rotate zeros forever, so it is always seeded.
      if (!mode && q_q == '0) q_d = start_val;
`ifdef SHIFT_RING_COUNTER_SELFCORRECT_EN
      if (!legal) q_d = start_val;
`endif
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign Q = q_q;

endmodule
